regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file. Successor to the single-port datapath regfile.
- Provides 1 write port and NUM_RD independent registered read ports.
- Adds write-to-read bypass, an optional hardwired-zero entry, and a hardware clear sequencer that zeroes every entry after reset.
- Sits between instruction decode (read addresses) and writeback (write port) in the core datapath.

Parameters:
- DATA_WIDTH, 16, bits per entry.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 0, if 1, entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  NUM_RD  per-port read request.
- rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_RD*DATA_WIDTH  packed registered read data.
- rd_valid  output  NUM_RD  per-port: rd_data slice k updated this cycle.
- ready  output  1  clear sequence done; accesses are honoured.

Behaviour:
- States:
  - INIT: clear in progress.
  - RUN: normal operation.
- Reset:
  - rst=1 at an edge forces state=INIT, init_ptr=0, ready=0, rd_data=0, rd_valid=0.
  - This applies from any state, including mid-INIT or mid-RUN; the clear restarts from entry 0.
  - Memory contents are not reset directly; the clear is done by INIT.
- INIT:
  - Each cycle with rst=0: mem[init_ptr] <= 0 and init_ptr increments.
  - When init_ptr == DEPTH-1 that entry is written and state becomes RUN; ready=1 from the next cycle.
  - ready rises exactly DEPTH cycles after the first edge with rst=0.
  - wr_en and rd_en are ignored; rd_valid stays 0 and rd_data holds 0.
- RUN write:
  - wr_en=1 writes mem[wr_addr] <= wr_data at the edge.
  - If ZERO_REG=1 and wr_addr==0, the write is dropped.
- RUN read, latency 1:
  - rd_en[k]=1 at edge N loads rd_data slice k and sets rd_valid[k]=1 for cycle N+1.
  - rd_en[k]=0 clears rd_valid[k]; rd_data slice k holds its last value.
  - Ports are fully independent; two ports may read the same address.
- Bypass:
  - If wr_en=1 and wr_addr==rd_addr[k] in the same cycle, rd_data[k] returns wr_data (new value), not the stored value.
  - Zero-register rule takes precedence: with ZERO_REG=1, a read of address 0 returns 0 even if bypassed.
- No address-range errors: every address < DEPTH by construction.
- Width rules: all widths are exact; no sign or zero extension inside the block.

Decomposition:
- Shared header/package regfile_pkg:
  - state encoding: RF_INIT=1'b0, RF_RUN=1'b1;
  - default DATA_WIDTH and ADDR_WIDTH constants, reused by decode and writeback.
- Sub-module regfile_rd_port is generated NUM_RD times. Its inputs:
  - storage-array read value;
  - wr_en/wr_addr/wr_data for bypass;
  - rd_en, rd_addr, ready.
  - It owns the rd_data/rd_valid registers and the bypass/zero mux.
- Top level holds storage, the INIT sequencer and write logic.

Test Plan:
- Clear sequence:
  - Preload all 16 entries (DEPTH=16) with 0xFFFF.
  - Pulse rst for 1 cycle.
  - Required: ready=0 for 16 cycles then 1; reading addresses 0..15 returns 0x0000 on every port.
- Basic write/read:
  - Write 0xA5A5 to addr 3 at cycle N.
  - rd_en[0]=1, rd_addr[0]=3 at cycle N+1.
  - Required: rd_data[0]=0xA5A5, rd_valid[0]=1 at cycle N+2.
- Bypass:
  - Same cycle: wr_en=1, wr_addr=7, wr_data=0x1234; rd_addr[1]=7, rd_en[1]=1.
  - Required: rd_data[1]=0x1234 next cycle.
  - Port 0 reading addr 6 in the same cycle returns its old value.
- Zero register, ZERO_REG=1:
  - Write 0xBEEF to addr 0, then read addr 0 on both ports.
  - Repeat with a same-cycle write (bypass case).
  - Required: 0x0000 in both cases.
- Reset mid-RUN:
  - Write 0x00FF to addr 5.
  - Assert rst during a cycle with rd_en=1.
  - Required: next cycle rd_valid=0 and rd_data=0; after re-clear completes (ready=1), addr 5 reads 0x0000.
- Gating and hold:
  - rd_en low for 3 cycles after a valid read returning 0x5555.
  - Required: rd_valid=0, rd_data holds 0x5555.
  - Write requests during INIT (ready=0): the entry reads 0 after ready rises.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sequencer state encoding and the default
// datapath widths that decode and writeback size themselves against.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_ADDR_WIDTH = 4;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: bypass/zero-register select followed by the
// rd_data/rd_valid output registers.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] next_data;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    next_data = mem_data;
    if (wr_en && (wr_addr == rd_addr)) next_data = wr_data;
    // The hardwired zero wins over a same-cycle write to entry 0.
    if ((ZERO_REG != 0) && (rd_addr == '0)) next_data = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (ready && rd_en) begin
      rd_data  <= next_data;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: storage, post-reset clear sequencer and
// write port; each read port is a regfile_rd_port instance.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic                         ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  rf_state_e             state;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic                  wr_ok;

  // state only changes at an edge, so ready is a registered output.
  assign ready = (state == RF_RUN);
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= RF_INIT;
      init_ptr <= '0;
    end else begin
      case (state)
        RF_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_ADDR) state <= RF_RUN;
        end
        default: state <= RF_RUN;
      endcase
    end
  end

  // NOTE: storage has no reset branch; the INIT sequence clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_INIT) mem[init_ptr] <= '0;
      else if (wr_ok)       mem[wr_addr]  <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] port_addr;
    assign port_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .mem_data (mem[port_addr]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en[k]),
      .rd_addr  (port_addr),
      .rd_data  (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (rd_valid[k])
    );
  end

endmodule
